run_length_detector: RTL and testbench

//  - Parametrised successor to the four-in-a-row w-input FSM.
//  - Samples serial input w on enabled clock edges and tracks the current run of identical bits.
//  - Asserts z while the last RUN_LEN samples are equal and the polarity is permitted by mode.
//  - Counts qualified run completions and exports a 4-bit state code for a HEX digit decoder.
//  - Sits between the board-level switch/key wrapper and the LEDG/HEX display logic.

---
 rtl/run_det_pkg.sv | 18 +
 rtl/sat_counter.sv | 34 +++
 rtl/run_length_detector.sv | 95 +++++++++
 tb/tb_run_length_detector.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// Shared types and the polarity-permission helper for the run-length detector.
package run_det_pkg;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  typedef enum logic [1:0] {M_BOTH, M_ONES, M_ZEROS, M_OFF} mode_t;

  // True when a run of polarity b may raise z / be counted under mode m.
  function automatic logic allow(input mode_t m, input logic b);
    case (m)
      M_BOTH:  allow = 1'b1;
      M_ONES:  allow = b;
      M_ZEROS: allow = ~b;
      default: allow = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/run_length_detector.sv
// Tracks the current run of identical w samples, flags runs of RUN_LEN under the
// selected polarity mode and counts qualified run completions.
module run_length_detector
  import run_det_pkg::*;
#(
  parameter  int RUN_LEN = 4,
  parameter  int MATCH_W = 8,
  localparam int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               en,
  input  logic               clr,
  input  logic               w,
  input  logic [1:0]         mode,
  output logic               z,
  output logic [CNT_W-1:0]   run_len,
  output logic               last_bit,
  output logic [MATCH_W-1:0] match_count,
  output logic [3:0]         state_code
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic             complete;
  logic             inc;
  mode_t            mode_e;
  logic [7:0]       run_ext;
  logic [2:0]       run_cap;

  assign mode_e = mode_t'(mode);

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    last_d   = last_q;
    complete = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      run_d   = '0;
      last_d  = 1'b0;
    end else if (en) begin
      if (state_q == S_IDLE) begin
        state_d = S_RUN;
        last_d  = w;
        run_d   = CNT_W'(1);
      end else if (w == last_q) begin
        // Saturate at RUN_LEN; only the RUN_LEN-1 -> RUN_LEN step is a completion.
        if (run_q < RUN_MAX) begin
          run_d    = run_q + 1'b1;
          complete = (run_q == RUN_MAX - 1'b1);
        end
      end else begin
        last_d = w;
        run_d  = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      run_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      last_q  <= last_d;
    end
  end

  // Qualified on the polarity being sampled, so a later mode change never counts old runs.
  assign inc = complete && allow(mode_e, w);

  sat_counter #(.W(MATCH_W)) u_match_cnt (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (clr),
    .inc    (inc),
    .q      (match_count)
  );

  assign z = (state_q == S_RUN) && (run_q == RUN_MAX) && allow(mode_e, last_q);

  assign run_ext    = 8'(run_q);
  assign run_cap    = (run_ext > 8'd7) ? 3'd7 : run_ext[2:0];
  assign state_code = (state_q == S_IDLE) ? 4'h0 : {last_q, run_cap};

  assign run_len  = run_q;
  assign last_bit = last_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench: four detector instances (RUN_LEN 4/2/9, and a 2-bit match counter)
// share one stimulus stream; each check targets the instance it is written for.
module tb_run_length_detector;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       w;
  logic [1:0] mode;

  int errors = 0;
  int checks = 0;

  logic       d4_z, d4_lb;
  logic [2:0] d4_rl;
  logic [7:0] d4_mc;
  logic [3:0] d4_sc;

  logic       dm_z, dm_lb;
  logic [2:0] dm_rl;
  logic [1:0] dm_mc;
  logic [3:0] dm_sc;

  logic       d2_z, d2_lb;
  logic [1:0] d2_rl;
  logic [7:0] d2_mc;
  logic [3:0] d2_sc;

  logic       d9_z, d9_lb;
  logic [3:0] d9_rl;
  logic [7:0] d9_mc;
  logic [3:0] d9_sc;

  run_length_detector #(.RUN_LEN(4), .MATCH_W(8)) u_d4 (
    .Clock(clk), .Resetn(rst_n), .en(en), .clr(clr), .w(w), .mode(mode),
    .z(d4_z), .run_len(d4_rl), .last_bit(d4_lb), .match_count(d4_mc), .state_code(d4_sc)
  );

  run_length_detector #(.RUN_LEN(4), .MATCH_W(2)) u_dm (
    .Clock(clk), .Resetn(rst_n), .en(en), .clr(clr), .w(w), .mode(mode),
    .z(dm_z), .run_len(dm_rl), .last_bit(dm_lb), .match_count(dm_mc), .state_code(dm_sc)
  );

  run_length_detector #(.RUN_LEN(2), .MATCH_W(8)) u_d2 (
    .Clock(clk), .Resetn(rst_n), .en(en), .clr(clr), .w(w), .mode(mode),
    .z(d2_z), .run_len(d2_rl), .last_bit(d2_lb), .match_count(d2_mc), .state_code(d2_sc)
  );

  run_length_detector #(.RUN_LEN(9), .MATCH_W(8)) u_d9 (
    .Clock(clk), .Resetn(rst_n), .en(en), .clr(clr), .w(w), .mode(mode),
    .z(d9_z), .run_len(d9_rl), .last_bit(d9_lb), .match_count(d9_mc), .state_code(d9_sc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_d4(input string tag, input logic ez, input int erl, input int esc, input int emc);
    chk({tag, ".d4.z"},  32'(d4_z),  32'(ez));
    chk({tag, ".d4.rl"}, 32'(d4_rl), 32'(erl));
    chk({tag, ".d4.sc"}, 32'(d4_sc), 32'(esc));
    chk({tag, ".d4.mc"}, 32'(d4_mc), 32'(emc));
  endtask

  task automatic chk_dm(input string tag, input logic ez, input int erl, input int esc, input int emc);
    chk({tag, ".dm.z"},  32'(dm_z),  32'(ez));
    chk({tag, ".dm.rl"}, 32'(dm_rl), 32'(erl));
    chk({tag, ".dm.sc"}, 32'(dm_sc), 32'(esc));
    chk({tag, ".dm.mc"}, 32'(dm_mc), 32'(emc));
  endtask

  task automatic chk_d2(input string tag, input logic ez, input int erl, input int esc, input int emc);
    chk({tag, ".d2.z"},  32'(d2_z),  32'(ez));
    chk({tag, ".d2.rl"}, 32'(d2_rl), 32'(erl));
    chk({tag, ".d2.sc"}, 32'(d2_sc), 32'(esc));
    chk({tag, ".d2.mc"}, 32'(d2_mc), 32'(emc));
  endtask

  task automatic chk_d9(input string tag, input logic ez, input int erl, input int esc, input int emc);
    chk({tag, ".d9.z"},  32'(d9_z),  32'(ez));
    chk({tag, ".d9.rl"}, 32'(d9_rl), 32'(erl));
    chk({tag, ".d9.sc"}, 32'(d9_sc), 32'(esc));
    chk({tag, ".d9.mc"}, 32'(d9_mc), 32'(emc));
  endtask

  // driver tasks: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge
  task automatic step(input logic b, input logic e);
    @(negedge clk);
    w  = b;
    en = e;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic run_bits(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b1);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    en  = 1'b1;
    w   = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    en  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    w     = 1'b0;
    mode  = 2'b00;
    #1;
    chk_d4("reset", 1'b0, 0, 4'h0, 0);
    chk("reset.d4.lb", 32'(d4_lb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset in the middle of a run
    run_bits(1'b1, 3);
    chk_d4("t1.pre", 1'b0, 3, 4'hB, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_d4("t1.async", 1'b0, 0, 4'h0, 0);
    chk("t1.async.d4.lb", 32'(d4_lb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // w = 1,1,1,1,1,0 under mode 00
    run_bits(1'b1, 3);
    chk_d4("t2.e3", 1'b0, 3, 4'hB, 0);
    step(1'b1, 1'b1);
    chk_d4("t2.e4", 1'b1, 4, 4'hC, 1);
    step(1'b1, 1'b1);
    chk_d4("t2.e5", 1'b1, 4, 4'hC, 1);
    step(1'b0, 1'b1);
    chk_d4("t2.e6", 1'b0, 1, 4'h1, 1);
    chk("t2.e6.d4.lb", 32'(d4_lb), 32'd0);
    chk_d2("t2.e6", 1'b0, 1, 4'h1, 1);
    chk_d9("t2.e6", 1'b0, 1, 4'h1, 0);

    // zeros run under ones-only mode, then mode switched without an edge
    do_clr();
    chk_d4("t3.clr", 1'b0, 0, 4'h0, 0);
    mode = 2'b01;
    run_bits(1'b0, 4);
    chk_d4("t3.ones_only", 1'b0, 4, 4'h4, 0);
    mode = 2'b00;
    #1;
    chk_d4("t3.mode_both", 1'b1, 4, 4'h4, 0);
    step(1'b0, 1'b1);
    chk_d4("t3.no_retro", 1'b1, 4, 4'h4, 0);

    // w = 1,1,1,0,0,0,0
    do_clr();
    run_bits(1'b1, 3);
    chk_d4("t4.e3", 1'b0, 3, 4'hB, 0);
    chk_d2("t4.e3", 1'b1, 2, 4'hA, 1);
    step(1'b0, 1'b1);
    chk_d4("t4.e4", 1'b0, 1, 4'h1, 0);
    run_bits(1'b0, 2);
    chk_d4("t4.e6", 1'b0, 3, 4'h3, 0);
    step(1'b0, 1'b1);
    chk_d4("t4.e7", 1'b1, 4, 4'h4, 1);
    chk_d2("t4.e7", 1'b1, 2, 4'h2, 2);
    chk_d9("t4.e7", 1'b0, 4, 4'h4, 0);

    // RUN_LEN=9: ten ones then a zero
    do_clr();
    run_bits(1'b1, 8);
    chk_d9("t2r9.e8", 1'b0, 8, 4'hF, 0);
    chk_d4("t2r9.e8", 1'b1, 4, 4'hC, 1);
    step(1'b1, 1'b1);
    chk_d9("t2r9.e9", 1'b1, 9, 4'hF, 1);
    step(1'b1, 1'b1);
    chk_d9("t2r9.e10", 1'b1, 9, 4'hF, 1);
    step(1'b0, 1'b1);
    chk_d9("t2r9.e11", 1'b0, 1, 4'h1, 1);

    // RUN_LEN=9: three ones then nine zeros
    do_clr();
    run_bits(1'b1, 3);
    run_bits(1'b0, 8);
    chk_d9("t4r9.e11", 1'b0, 8, 4'h7, 0);
    step(1'b0, 1'b1);
    chk_d9("t4r9.e12", 1'b1, 9, 4'h7, 1);
    chk_d4("t4r9.e12", 1'b1, 4, 4'h4, 1);
    chk_d2("t4r9.e12", 1'b1, 2, 4'h2, 2);

    // enable gating with w held at 1
    do_clr();
    step(1'b1, 1'b1);
    chk_d4("t5.en1", 1'b0, 1, 4'h9, 0);
    step(1'b1, 1'b0);
    chk_d4("t5.en0a", 1'b0, 1, 4'h9, 0);
    step(1'b1, 1'b1);
    chk_d4("t5.en1b", 1'b0, 2, 4'hA, 0);
    step(1'b1, 1'b0);
    chk_d4("t5.en0b", 1'b0, 2, 4'hA, 0);
    step(1'b1, 1'b1);
    chk_d4("t5.en1c", 1'b0, 3, 4'hB, 0);
    step(1'b1, 1'b0);
    chk_d4("t5.en0c", 1'b0, 3, 4'hB, 0);
    step(1'b1, 1'b1);
    chk_d4("t5.en1d", 1'b1, 4, 4'hC, 1);

    // six separate runs, 2-bit match counter saturates
    do_clr();
    for (int r = 0; r < 6; r++) run_bits((r % 2 == 0) ? 1'b1 : 1'b0, 4);
    chk_dm("t6.sat", 1'b1, 4, 4'h4, 3);
    chk_d4("t6.six", 1'b1, 4, 4'h4, 6);
    mode = 2'b11;
    #1;
    chk("t6.mode_off.dm.z", 32'(dm_z), 32'd0);
    mode = 2'b00;
    run_bits(1'b1, 3);
    chk_dm("t6.pre_clr", 1'b0, 3, 4'hB, 3);
    // clr on the edge that would complete the run
    @(negedge clk);
    clr = 1'b1;
    en  = 1'b1;
    w   = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    en  = 1'b0;
    chk_dm("t6.clr_wins", 1'b0, 0, 4'h0, 0);
    chk_d4("t6.clr_wins", 1'b0, 0, 4'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
